divider_unit: RTL and testbench

DIVIDER_UNIT -- requirements
Module: divider_unit

---
 rtl/divider_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_divider_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// ============================================================================
// Module      : divider_unit
// Description : Iterative 32-bit restoring divider for DIV/DIVU/REM/REMU.
//               One quotient bit per clock, with a valid/ready handshake on
//               both sides and a pipeline flush.
//               Optional feature macro: DIVIDER_SIGNED_EN
//                 defined   -> signed DIV/REM with sign and overflow handling
//                 undefined -> DIV behaves as DIVU, REM behaves as REMU
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// 32-bit unsigned less-than comparator; L is high when a_i < b_i.
module divider_ltu32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        L
);
    // Plain magnitude comparison
    assign L = (a_i < b_i);
endmodule

module divider_unit #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [31:0]      rs1,
    input  logic [31:0]      rs2,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        dvd_q, dvd_d;        // dividend bits in, quotient bits out
    logic [31:0]        dvs_q, dvs_d;        // divisor magnitude
    logic [32:0]        rem_q, rem_d;        // partial remainder
    logic [4:0]         cnt_q, cnt_d;        // iteration counter
    logic               sel_rem_q, sel_rem_d;
    logic [TAG_W-1:0]   tag_q, tag_d;        // tag of the op in flight
    logic [31:0]        result_q, result_d;
    logic [TAG_W-1:0]   tag_out_q, tag_out_d;

    // Operand decode at acceptance time
    logic [31:0]        w_mag1, w_mag2;
    logic               w_ovf;
    logic               w_unused;

    // One restoring step
    logic [32:0]        w_shift, w_diff, w_rem_next;
    logic [31:0]        w_quo_next, w_quo_fin, w_rem_fin;
    logic               w_lt, w_sub;

`ifdef DIVIDER_SIGNED_EN
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               w_s1, w_s2;

    // Signed ops take magnitudes; track which results need negation
    assign w_s1     = ~op[0] & rs1[31];
    assign w_s2     = ~op[0] & rs2[31];
    assign w_mag1   = w_s1 ? (~rs1 + 32'd1) : rs1;
    assign w_mag2   = w_s2 ? (~rs2 + 32'd1) : rs2;
    assign w_ovf    = ~op[0] & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
    assign w_quo_fin = neg_quo_q ? (~w_quo_next + 32'd1) : w_quo_next;
    assign w_rem_fin = neg_rem_q ? (~w_rem_next[31:0] + 32'd1) : w_rem_next[31:0];
    assign w_unused = rem_q[32];

    // Sign flags captured with the operands
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Sign flags load only on acceptance
    always_comb begin
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (state_q == S_IDLE && in_valid && !flush) begin
            neg_quo_d = w_s1 ^ w_s2;
            neg_rem_d = w_s1;
        end
    end
`else
    assign w_mag1    = rs1;
    assign w_mag2    = rs2;
    assign w_ovf     = 1'b0;
    assign w_quo_fin = w_quo_next;
    assign w_rem_fin = w_rem_next[31:0];
    assign w_unused  = rem_q[32] ^ op[0];
`endif

    // Shift next dividend bit in; subtract when the divisor fits
    assign w_shift    = {rem_q[31:0], dvd_q[31]};
    assign w_sub      = w_shift[32] | ~w_lt;
    assign w_diff     = w_shift - {1'b0, dvs_q};
    assign w_rem_next = w_sub ? w_diff : w_shift;
    assign w_quo_next = {dvd_q[30:0], w_sub};

    divider_ltu32 u_cmp (
        .a_i (w_shift[31:0]),
        .b_i (dvs_q),
        .L   (w_lt)
    );

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY) || (state_q == S_DONE);
    assign result    = result_q;
    assign tag_out   = tag_out_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            sel_rem_q <= 1'b0;
            tag_q     <= '0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            sel_rem_q <= sel_rem_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
        end
    end

    // Next-state and datapath update; flush overrides everything but reset
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        sel_rem_d = sel_rem_q;
        tag_d     = tag_q;
        result_d  = result_q;
        tag_out_d = tag_out_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sel_rem_d = op[1];
                    tag_d     = tag_in;
                    dvd_d     = w_mag1;
                    dvs_d     = w_mag2;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (rs2 == 32'd0) begin
                        // Divide by zero: all-ones quotient, dividend as remainder
                        result_d  = op[1] ? rs1 : 32'hFFFF_FFFF;
                        tag_out_d = tag_in;
                        state_d   = S_DONE;
                    end else if (w_ovf) begin
                        result_d  = op[1] ? 32'd0 : 32'h8000_0000;
                        tag_out_d = tag_in;
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                dvd_d = w_quo_next;
                rem_d = w_rem_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d  = sel_rem_q ? w_rem_fin : w_quo_fin;
                    tag_out_d = tag_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d   = S_IDLE;
            result_d  = result_q;
            tag_out_d = tag_out_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_divider_unit.sv
// ============================================================================
// Module      : tb_divider_unit
// Description : Self-checking bench for divider_unit with a result
//               scoreboard. Honours DIVIDER_SIGNED_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider_unit;

    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [31:0]   rs1, rs2;
    logic [TW-1:0] tag_in;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   result;
    logic [TW-1:0] tag_out;
    logic          busy;

    typedef struct {
        logic [31:0]   res;
        logic [TW-1:0] tag;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    divider_unit #(.TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .tag_in    (tag_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .tag_out   (tag_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic bit is_signed_op(input logic [1:0] o);
`ifdef DIVIDER_SIGNED_EN
        return !o[0];
`else
        return 1'b0;
`endif
    endfunction

    // Reference result of the M-extension division semantics
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb_;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (is_signed_op(o)) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
            sa  = a;
            sb_ = b;
            return o[1] ? 32'(sa % sb_) : 32'(sa / sb_);
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 0;
        if (is_signed_op(o) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Present one request while IDLE; it is accepted on the next edge
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
        exp_t e;
        check("in_ready_before_issue", in_ready, 1'b1);
        op = o; rs1 = a; rs2 = b; tag_in = t; in_valid = 1'b1;
        e.res = ref_res(o, a, b);
        e.tag = t;
        e.lat = ref_lat(o, a, b);
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid, then compare head of scoreboard
    task automatic wait_and_check(input string name);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        check({name, "_latency"}, n, e.lat);
        check({name, "_result"}, result, e.res);
        check({name, "_tag"}, tag_out, e.tag);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_consume", out_valid, 1'b0);
        check("in_ready_after_consume", in_ready, 1'b1);
    endtask

    task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
        issue(o, a, b, t);
        wait_and_check(name);
        consume();
    endtask

    initial begin
        bit   seen;
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0;
        tag_in = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_result", result, 32'd0);
        check("rst_tag_out", tag_out, '0);
        rst = 1'b0;

        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd1);
        do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd2);
        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3);
        do_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4);
        do_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd5);
        do_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 5'd6);
        do_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 5'd7);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        do_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd10);
        do_op("rem_m7_0", OP_REM, 32'hFFFF_FFF9, 32'd0, 5'd11);

        // Flush after ten iterations: idle next edge, never a result
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd12);
        repeat (10) @(posedge clk);
        #1;
        check("flush_busy_before", busy, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(sb.pop_back());
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_busy", busy, 1'b0);
        check("flush_out_valid", out_valid, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_late_valid", seen, 1'b0);

        // Result held while writeback stalls; no accept on the consuming edge
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd13);
        e = sb[0];
        wait_and_check("stall");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_result", result, e.res);
            check("stall_tag", tag_out, e.tag);
            check("stall_in_ready", in_ready, 1'b0);
        end
        op = OP_DIVU; rs1 = 32'd9; rs2 = 32'd3; tag_in = 5'd14;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("no_accept_on_consume_ready", in_ready, 1'b1);
        check("no_accept_on_consume_busy", busy, 1'b0);

        // Flush wins over out_ready in DONE
        issue(OP_REMU, 32'd77, 32'd0, 5'd15);
        wait_and_check("flush_done_pre");
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        check("flush_done_valid", out_valid, 1'b0);
        check("flush_done_ready", in_ready, 1'b1);

        // Reset while a result waits
        issue(OP_DIVU, 32'd5, 32'd0, 5'd16);
        wait_and_check("rst_done_pre");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_done_out_valid", out_valid, 1'b0);
        check("rst_done_in_ready", in_ready, 1'b1);
        check("rst_done_result", result, 32'd0);
        check("rst_done_tag", tag_out, '0);

        // Random operands with a spread of divisor sizes
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            logic [1:0]  o;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            do_op("random", o, a, b, 5'(i + 17));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
